dds_param_ctrl: RTL and testbench



---
 rtl/dds_pkg.sv | 23 ++
 rtl/ftw_seq_mult.sv | 45 ++++
 rtl/dds_param_ctrl.sv | 116 +++++++++++
 tb/tb_dds_param_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared DDS constants: widths, tuning step, wave encodings.
// Imported by the control, phase accumulator and LUT blocks.
package dds_pkg;

  localparam int unsigned FTW_W   = 32;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned IDX_MAX = 15;

  localparam logic [FTW_W-1:0] FTW_STEP = 32'd178957;
  localparam logic [FTW_W-1:0] FTW_RST  = FTW_STEP;

  localparam logic [1:0] WAVE_SINE = 2'd0;
  localparam logic [1:0] WAVE_SQR  = 2'd1;
  localparam logic [1:0] WAVE_TRI  = 2'd2;
  localparam logic [1:0] WAVE_SAW  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ftw_seq_mult.sv
// Repeated-add multiplier: product = (idx+1) * FTW_STEP.
// Ports: CLK, RESET, start, idx in; done (last add), product out.
module ftw_seq_mult #(
  parameter int unsigned       FTW_W    = 32,
  parameter int unsigned       IDX_W    = 4,
  parameter logic [FTW_W-1:0]  FTW_STEP = 32'd178957
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [IDX_W-1:0] idx,
  output logic             done,
  output logic [FTW_W-1:0] product
);

  logic             run;
  logic [FTW_W-1:0] acc;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] tgt;

  // done flags the cycle carrying the final addition;
  // product already includes it
  assign done    = run && (cnt == tgt);
  assign product = acc + FTW_STEP;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      run <= 1'b0;
      acc <= '0;
      cnt <= '0;
      tgt <= '0;
    end else if (start) begin
      run <= 1'b1;
      acc <= '0;
      cnt <= '0;
      tgt <= idx;
    end else if (run) begin
      acc <= acc + FTW_STEP;
      cnt <= cnt + IDX_W'(1);
      if (cnt == tgt)
        run <= 1'b0;
    end
  end

endmodule

// File: rtl/dds_param_ctrl.sv
// DDS parameter control: buttons -> wave/index -> FTW commit.
// Ports: CLK, RESET, iBtnWave/Up/Dn pulses; oWaveSel, oFreqIdx,
// oFTW, oUpdate strobe, oBusy. Option: DDS_PARAM_WRAP_EN.
module dds_param_ctrl #(
  parameter int unsigned      FTW_W    = dds_pkg::FTW_W,
  parameter logic [FTW_W-1:0] FTW_STEP = dds_pkg::FTW_STEP,
  parameter int unsigned      IDX_W    = dds_pkg::IDX_W,
  parameter int unsigned      IDX_MAX  = dds_pkg::IDX_MAX
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             iBtnWave,
  input  logic             iBtnUp,
  input  logic             iBtnDn,
  output logic [1:0]       oWaveSel,
  output logic [IDX_W-1:0] oFreqIdx,
  output logic [FTW_W-1:0] oFTW,
  output logic             oUpdate,
  output logic             oBusy
);

  import dds_pkg::*;

  localparam logic [IDX_W-1:0] IMAX = IDX_W'(IDX_MAX);
  localparam logic [IDX_W-1:0] IONE = IDX_W'(1);

  state_e           state;
  logic [1:0]       pend_wave;
  logic [IDX_W-1:0] pend_idx;

  logic             up;
  logic             dn;
  logic [IDX_W-1:0] nidx;
  logic [1:0]       nwave;
  logic             go;
  logic             m_done;
  logic [FTW_W-1:0] m_prod;

  always_comb begin
    up    = iBtnUp & ~iBtnDn;
    dn    = iBtnDn & ~iBtnUp;
    nidx  = oFreqIdx;
    unique case (1'b1)
      up: begin
        if (oFreqIdx != IMAX)
          nidx = oFreqIdx + IONE;
`ifdef DDS_PARAM_WRAP_EN
        else
          nidx = '0;
`endif
      end
      dn: begin
        if (oFreqIdx != '0)
          nidx = oFreqIdx - IONE;
`ifdef DDS_PARAM_WRAP_EN
        else
          nidx = IMAX;
`endif
      end
      default: ;
    endcase
    nwave = iBtnWave ? oWaveSel + 2'd1 : oWaveSel;
    go    = (state == S_IDLE) &&
            ((nidx != oFreqIdx) || (nwave != oWaveSel));
  end

  assign oBusy = (state != S_IDLE);

  ftw_seq_mult #(
    .FTW_W    (FTW_W),
    .IDX_W    (IDX_W),
    .FTW_STEP (FTW_STEP)
  ) u_mult (
    .CLK     (CLK),
    .RESET   (RESET),
    .start   (go),
    .idx     (nidx),
    .done    (m_done),
    .product (m_prod)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      pend_wave <= WAVE_SINE;
      pend_idx  <= '0;
      oWaveSel  <= WAVE_SINE;
      oFreqIdx  <= '0;
      oFTW      <= FTW_STEP;
      oUpdate   <= 1'b0;
    end else begin
      oUpdate <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (go) begin
            pend_wave <= nwave;
            pend_idx  <= nidx;
            state     <= S_CALC;
          end
        end
        S_CALC: begin
          if (m_done) begin
            oFTW     <= m_prod;
            oFreqIdx <= pend_idx;
            oWaveSel <= pend_wave;
            oUpdate  <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_param_ctrl.sv
// Self-checking bench for dds_param_ctrl.
// Table vectors, random presses vs model, corner sequences.
module tb_dds_param_ctrl;

  localparam int STEP = 178957;
  localparam int IMAX = 15;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        iBtnWave = 1'b0;
  logic        iBtnUp = 1'b0;
  logic        iBtnDn = 1'b0;
  logic [1:0]  oWaveSel;
  logic [3:0]  oFreqIdx;
  logic [31:0] oFTW;
  logic        oUpdate;
  logic        oBusy;

  int checks = 0;
  int failures = 0;
  int m_wave = 0;
  int m_idx = 0;

  always #5 CLK = ~CLK;

  dds_param_ctrl dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .iBtnWave (iBtnWave),
    .iBtnUp   (iBtnUp),
    .iBtnDn   (iBtnDn),
    .oWaveSel (oWaveSel),
    .oFreqIdx (oFreqIdx),
    .oFTW     (oFTW),
    .oUpdate  (oUpdate),
    .oBusy    (oBusy)
  );

  typedef struct {
    logic w;
    logic u;
    logic d;
    bit   tx;
    int   ew;
    int   ei;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    m_wave = 0;
    m_idx = 0;
  endtask

  // expected result of a press, from the index/wave rules
  task automatic model(input logic w, input logic u, input logic d,
                       output bit tx, output int nw, output int ni);
    int t;
    t = m_idx + (u ? 1 : 0) - (d ? 1 : 0);
`ifdef DDS_PARAM_WRAP_EN
    if (t > IMAX) t = 0;
    if (t < 0) t = IMAX;
`else
    if (t > IMAX) t = IMAX;
    if (t < 0) t = 0;
`endif
    ni = t;
    nw = (m_wave + (w ? 1 : 0)) % 4;
    tx = (ni != m_idx) || (nw != m_wave);
  endtask

  // entered at a negedge with DUT idle
  task automatic apply(input logic w, input logic u, input logic d,
                       input bit tx, input int ew, input int ei);
    logic [1:0]  pw;
    logic [3:0]  pi;
    logic [31:0] pf;
    int n;
    bit seen;
    bit stab;
    bit bok;
    pw = oWaveSel;
    pi = oFreqIdx;
    pf = oFTW;
    iBtnWave = w;
    iBtnUp = u;
    iBtnDn = d;
    @(negedge CLK);
    iBtnWave = 1'b0;
    iBtnUp = 1'b0;
    iBtnDn = 1'b0;
    n = 0;
    seen = 0;
    stab = 1;
    bok = 1;
    for (int k = 1; k <= 40; k++) begin
      if (oUpdate) begin
        seen = 1;
        n = k;
        break;
      end
      if (oWaveSel !== pw || oFreqIdx !== pi || oFTW !== pf)
        stab = 0;
      if (oBusy !== logic'(tx)) bok = 0;
      @(negedge CLK);
    end
    chk("update_seen", 32'(seen), 32'(tx));
    chk("stable_before_update", 32'(stab), 32'd1);
    chk("busy_window", 32'(bok), 32'd1);
    if (tx && seen) begin
      chk("latency", n, ei + 2);
      chk("wave", 32'(oWaveSel), ew);
      chk("idx", 32'(oFreqIdx), ei);
      chk("ftw", oFTW, 32'((ei + 1) * STEP));
      chk("busy_in_update", 32'(oBusy), 32'd1);
      @(negedge CLK);
      chk("update_one_shot", 32'(oUpdate), 32'd0);
      chk("idle_after", 32'(oBusy), 32'd0);
    end
    if (tx) begin
      m_wave = ew;
      m_idx = ei;
    end
  endtask

  task automatic press(input logic w, input logic u, input logic d);
    bit tx;
    int nw;
    int ni;
    model(w, u, d, tx, nw, ni);
    apply(w, u, d, tx, nw, ni);
  endtask

  initial begin
    bit nu;
    int pidx;
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 0, 1};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 1};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1, 1};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 2, 1};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 3, 1};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 1};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1, 2};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1, 1};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1, 0};
`ifdef DDS_PARAM_WRAP_EN
    tbl[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1, 15};
`else
    tbl[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 0};
`endif

    do_reset();
    nu = 0;
    for (int k = 0; k < 100; k++) begin
      if (oUpdate !== 1'b0 || oBusy !== 1'b0) nu = 1;
      @(negedge CLK);
    end
    chk("idle_no_update", 32'(nu), 32'd0);
    chk("rst_wave", 32'(oWaveSel), 32'd0);
    chk("rst_idx", 32'(oFreqIdx), 32'd0);
    chk("rst_ftw", oFTW, 32'd178957);

    foreach (tbl[i])
      apply(tbl[i].w, tbl[i].u, tbl[i].d,
            tbl[i].tx, tbl[i].ew, tbl[i].ei);

    do_reset();
    for (int k = 0; k < 15; k++) press(1'b0, 1'b1, 1'b0);
    chk("up15_ftw", oFTW, 32'd2863312);
    chk("up15_idx", 32'(oFreqIdx), 32'd15);
    press(1'b0, 1'b1, 1'b0);
`ifdef DDS_PARAM_WRAP_EN
    chk("up16_ftw", oFTW, 32'd178957);
`else
    chk("up16_ftw", oFTW, 32'd2863312);
`endif

    // second up pulse while busy must be dropped
    do_reset();
    press(1'b0, 1'b1, 1'b0);
    pidx = m_idx;
    @(negedge CLK);
    iBtnUp = 1'b1;
    @(negedge CLK);
    iBtnUp = 1'b1;
    @(negedge CLK);
    iBtnUp = 1'b0;
    nu = 0;
    for (int k = 0; k < 40; k++) begin
      if (oUpdate) nu = 1;
      @(negedge CLK);
    end
    chk("drop_one_update", 32'(nu), 32'd1);
    chk("drop_idx", 32'(oFreqIdx), 32'(pidx + 1));
    chk("drop_ftw", oFTW, 32'((pidx + 2) * STEP));
    m_idx = pidx + 1;

    for (int k = 0; k < 150; k++)
      press(logic'($urandom_range(0, 2) == 0),
            logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 1)));

    // reset while computing index 10
    do_reset();
    for (int k = 0; k < 9; k++) press(1'b0, 1'b1, 1'b0);
    iBtnUp = 1'b1;
    @(negedge CLK);
    iBtnUp = 1'b0;
    repeat (2) @(negedge CLK);
    chk("calc_busy", 32'(oBusy), 32'd1);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    m_wave = 0;
    m_idx = 0;
    chk("abort_wave", 32'(oWaveSel), 32'd0);
    chk("abort_idx", 32'(oFreqIdx), 32'd0);
    chk("abort_ftw", oFTW, 32'd178957);
    chk("abort_busy", 32'(oBusy), 32'd0);
    chk("abort_upd", 32'(oUpdate), 32'd0);
    nu = 0;
    for (int k = 0; k < 30; k++) begin
      if (oUpdate || oBusy) nu = 1;
      @(negedge CLK);
    end
    chk("abort_quiet", 32'(nu), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
